// File: rtl/nx_indirect_access_cntrl_if.sv
// Shared memory port between the indirect-access controller and the table.
// The controller drives strobes/address/data; the arbiter returns grant.
interface nx_indirect_access_cntrl_if #(
  parameter int AW = 5,
  parameter int DW = 64,
  parameter int IW = 4
);
  logic          sw_cs;
  logic          sw_ce;
  logic          sw_we;
  logic [AW-1:0] sw_add;
  logic [DW-1:0] sw_wdat;
  logic [DW-1:0] sw_rdat;
  logic          sw_match;
  logic [IW-1:0] sw_aindex;
  logic          grant;
  logic          yield;

  modport master (
    output sw_cs, sw_ce, sw_we, sw_add, sw_wdat, yield,
    input  sw_rdat, sw_match, sw_aindex, grant
  );

  modport slave (
    input  sw_cs, sw_ce, sw_we, sw_add, sw_wdat, yield,
    output sw_rdat, sw_match, sw_aindex, grant
  );
endinterface

// File: rtl/nx_indirect_access_cntrl.sv
// Indirect-access command controller: decodes register commands and
// sequences read/write/compare/reset/init cycles on the shared memory port.
module nx_indirect_access_cntrl #(
  parameter logic [10:0] CMND_ADDRESS = 11'h40C,
  parameter int          N_DATA_BITS  = 64,
  parameter int          N_ENTRIES    = 32,
  parameter int          N_TIMER_BITS = 4,
  parameter logic [15:0] CAPABILITIES = 16'h8023,
  parameter logic [3:0]  MEM_TYPE     = 4'h2,
  localparam int         A = $clog2(N_ENTRIES)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_stb,
  input  logic [10:0]            reg_addr,
  input  logic [3:0]             cmnd_op,
  input  logic [A-1:0]           cmnd_addr,
  input  logic                   cmnd_table_id,
  input  logic [A-1:0]           addr_limit,
  input  logic [N_DATA_BITS-1:0] wr_dat,
  output logic [2:0]             stat_code,
  output logic [4:0]             stat_datawords,
  output logic [A-1:0]           stat_addr,
  output logic                   stat_table_id,
  output logic [15:0]            capability_lst,
  output logic [3:0]             capability_type,
  output logic                   enable,
  output logic [N_DATA_BITS-1:0] rd_dat,
  output logic                   reset,
  nx_indirect_access_cntrl_if.master mem
);

  typedef enum logic [3:0] {
    S_READY,
    S_DO_WRITE,
    S_DO_READ,
    S_READ_DONE,
    S_DO_COMPARE,
    S_COMPARE_WAIT,
    S_COMPARE_DONE,
    S_DO_RESET,
    S_DO_INIT,
    S_PDN,
    S_ERROR
  } state_t;

  localparam logic [2:0] ST_RDY = 3'd0;
  localparam logic [2:0] ST_BSY = 3'd1;
  localparam logic [2:0] ST_TMO = 3'd2;
  localparam logic [2:0] ST_OVR = 3'd3;
  localparam logic [2:0] ST_NXM = 3'd4;
  localparam logic [2:0] ST_UOP = 3'd5;
  localparam logic [2:0] ST_PDN = 3'd7;

  state_t                  state;
  state_t                  nxt;
  logic                    init_r;
  logic                    sim_tmo_r;
  logic [N_TIMER_BITS-1:0] timer_r;
  logic [N_TIMER_BITS-1:0] timer_nxt;
  logic [A-1:0]            rst_addr_r;
  logic                    cs_r;
  logic                    ce_r;
  logic                    we_r;
  logic                    rst_r;
  logic                    rst_or_ini_r;
  logic [2:0]              stat_nxt;

  logic cmd_hit;
  logic cmnd_issued;
  logic op_rd;
  logic op_wr;
  logic op_en;
  logic op_dis;
  logic op_rst;
  logic op_ini;
  logic op_start;
  logic op_cmp;
  logic op_uop;
  logic op_sim;
  logic op_ack;

  logic [A-1:0] maxaddr;
  logic         badaddr;
  logic         igrant;
  logic         timeout;
  logic         busy;
  logic         cs_nxt;
  logic         ce_nxt;
  logic         we_nxt;
  logic         rst_nxt;
  logic         ri_nxt;

  always_comb begin
    cmd_hit  = wr_stb && (reg_addr == CMND_ADDRESS);
    op_rd    = 1'b0;
    op_wr    = 1'b0;
    op_en    = 1'b0;
    op_dis   = 1'b0;
    op_rst   = 1'b0;
    op_ini   = 1'b0;
    op_start = 1'b0;
    op_cmp   = 1'b0;
    op_uop   = 1'b0;
    op_sim   = 1'b0;
    op_ack   = 1'b0;
    if (cmd_hit) begin
      unique case (cmnd_op)
        4'd1:    op_rd    = 1'b1;
        4'd2:    op_wr    = 1'b1;
        4'd3:    op_en    = 1'b1;
        4'd4:    op_dis   = 1'b1;
        4'd5:    op_rst   = 1'b1;
        4'd6,
        4'd7:    op_ini   = 1'b1;
        4'd8:    op_start = 1'b1;
        4'd9:    op_cmp   = 1'b1;
        4'd10,
        4'd11,
        4'd12,
        4'd13:   op_uop   = 1'b1;
        4'd14:   op_sim   = 1'b1;
        4'd15:   op_ack   = 1'b1;
        default: ;
      endcase
    end
    cmnd_issued = cmd_hit && (cmnd_op != 4'd0) && !op_sim;
  end

  // Only table 0 exists, so any other table id is a non-existent address.
  assign maxaddr = init_r ? '0 : addr_limit;
  assign badaddr = cmnd_issued &&
                   ((cmnd_addr > maxaddr) || cmnd_table_id);
  assign igrant  = mem.grant && !sim_tmo_r;
  assign timeout = &timer_r;
  assign busy    = !(state inside {S_READY, S_PDN, S_ERROR});

  always_comb begin
    nxt = state;
    unique case (state)
      S_READY: begin
        unique case (1'b1)
          op_wr:   nxt = S_DO_WRITE;
          op_rd:   nxt = S_DO_READ;
          op_cmp:  nxt = S_DO_COMPARE;
          op_rst:  nxt = S_DO_RESET;
          op_ini:  nxt = S_DO_INIT;
          op_dis:  nxt = S_PDN;
          op_uop:  nxt = S_ERROR;
          default: ;
        endcase
      end
      S_DO_WRITE:     if (igrant) nxt = S_READY;
      S_DO_READ:      if (igrant) nxt = S_READ_DONE;
      S_READ_DONE:    nxt = S_READY;
      S_DO_COMPARE:   if (igrant) nxt = S_COMPARE_WAIT;
      S_COMPARE_WAIT: nxt = S_COMPARE_DONE;
      S_COMPARE_DONE: nxt = S_READY;
      S_DO_RESET:     nxt = S_READY;
      S_DO_INIT: begin
        if (igrant && (rst_addr_r == cmnd_addr)) nxt = S_READY;
      end
      S_PDN:          if (op_en) nxt = S_READY;
      S_ERROR: begin
        if (op_ack) nxt = init_r ? S_PDN : S_READY;
      end
      default:        nxt = S_READY;
    endcase
    if (busy && (timeout || cmnd_issued)) nxt = S_ERROR;
    if (badaddr) nxt = S_ERROR;
  end

  // Error cause is captured once on entry and frozen until acknowledged.
  always_comb begin
    stat_nxt = ST_BSY;
    if (nxt == S_ERROR) begin
      if (state == S_ERROR) stat_nxt = stat_code;
      else if (op_uop)      stat_nxt = ST_UOP;
      else if (badaddr)     stat_nxt = ST_NXM;
      else if (timeout)     stat_nxt = ST_TMO;
      else                  stat_nxt = ST_OVR;
    end else if (nxt == S_PDN) begin
      stat_nxt = ST_PDN;
    end else if (nxt == S_READY) begin
      stat_nxt = ST_RDY;
    end
  end

  always_comb begin
    cs_nxt  = nxt inside {S_DO_WRITE, S_DO_READ, S_DO_COMPARE,
                          S_DO_RESET, S_DO_INIT};
    we_nxt  = nxt inside {S_DO_WRITE, S_DO_RESET, S_DO_INIT};
    ce_nxt  = (nxt == S_DO_COMPARE);
    rst_nxt = (nxt == S_DO_RESET);
    ri_nxt  = nxt inside {S_DO_RESET, S_DO_INIT};
    timer_nxt = (cs_nxt && !igrant) ? timer_r + 1'b1 : '0;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_READY;
      init_r       <= 1'b0;
      stat_code    <= ST_RDY;
      rd_dat       <= '0;
      timer_r      <= '0;
      sim_tmo_r    <= 1'b0;
      rst_addr_r   <= '0;
      cs_r         <= 1'b0;
      ce_r         <= 1'b0;
      we_r         <= 1'b0;
      rst_r        <= 1'b0;
      rst_or_ini_r <= 1'b0;
    end else begin
      state        <= nxt;
      stat_code    <= stat_nxt;
      timer_r      <= timer_nxt;
      cs_r         <= cs_nxt;
      ce_r         <= ce_nxt;
      we_r         <= we_nxt;
      rst_r        <= rst_nxt;
      rst_or_ini_r <= ri_nxt;

      if (nxt == S_PDN) init_r <= 1'b1;
      else if (state == S_PDN && nxt == S_READY) init_r <= 1'b0;

      if (timeout) sim_tmo_r <= 1'b0;
      else if (op_sim) sim_tmo_r <= 1'b1;

      if (op_start) rst_addr_r <= cmnd_addr;
      else if (op_rst) rst_addr_r <= '0;
      else if (state == S_DO_INIT) rst_addr_r <= rst_addr_r + A'(igrant);

      unique case (state)
        S_READ_DONE:    rd_dat <= mem.sw_rdat;
        S_COMPARE_DONE: rd_dat <= N_DATA_BITS'({mem.sw_match, mem.sw_aindex});
        S_PDN:          rd_dat <= wr_dat;
        default: ;
      endcase
    end
  end

  assign mem.sw_cs   = cs_r;
  assign mem.sw_ce   = ce_r;
  assign mem.sw_we   = we_r;
  assign mem.sw_add  = rst_or_ini_r ? rst_addr_r : cmnd_addr;
  assign mem.sw_wdat = rst_r ? '0 : wr_dat;
  assign mem.yield   = timer_r[N_TIMER_BITS-1];

  assign reset           = rst_r;
  assign enable          = !init_r;
  assign stat_addr       = maxaddr;
  assign stat_datawords  = 5'd1;
  assign stat_table_id   = 1'b0;
  assign capability_lst  = CAPABILITIES;
  assign capability_type = MEM_TYPE;

endmodule

// File: tb/tb_nx_indirect_access_cntrl.sv
// Scoreboard bench for nx_indirect_access_cntrl: expected memory cycles and
// status transitions are queued by stimulus and checked by a monitor.
module tb_nx_indirect_access_cntrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        wr_stb;
  logic [10:0] reg_addr;
  logic [3:0]  cmnd_op;
  logic [4:0]  cmnd_addr;
  logic        cmnd_table_id;
  logic [4:0]  addr_limit;
  logic [63:0] wr_dat;
  logic [2:0]  stat_code;
  logic [4:0]  stat_datawords;
  logic [4:0]  stat_addr;
  logic        stat_table_id;
  logic [15:0] capability_lst;
  logic [3:0]  capability_type;
  logic        enable;
  logic [63:0] rd_dat;
  logic        reset;

  nx_indirect_access_cntrl_if #(.AW(5), .DW(64), .IW(4)) mif ();

  nx_indirect_access_cntrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_stb          (wr_stb),
    .reg_addr        (reg_addr),
    .cmnd_op         (cmnd_op),
    .cmnd_addr       (cmnd_addr),
    .cmnd_table_id   (cmnd_table_id),
    .addr_limit      (addr_limit),
    .wr_dat          (wr_dat),
    .stat_code       (stat_code),
    .stat_datawords  (stat_datawords),
    .stat_addr       (stat_addr),
    .stat_table_id   (stat_table_id),
    .capability_lst  (capability_lst),
    .capability_type (capability_type),
    .enable          (enable),
    .rd_dat          (rd_dat),
    .reset           (reset),
    .mem             (mif)
  );

  typedef struct {
    string       nm;
    logic        ce;
    logic        we;
    logic        rs;
    logic [4:0]  ad;
    logic [63:0] wd;
  } mem_exp_t;

  typedef struct {
    string       nm;
    logic [2:0]  st;
    logic        y;
    logic        en;
    logic [4:0]  sa;
    logic        cr;
    logic [63:0] rd;
  } st_exp_t;

  mem_exp_t mem_q[$];
  st_exp_t  st_q[$];
  int       n_cmp = 0;
  int       n_bad = 0;
  logic     mon_on = 1'b0;
  logic [3:0] prev;

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm, input logic [127:0] act);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %0h expected no event", nm, act);
  endtask

  task automatic exp_mem(input string nm, input logic ce, input logic we,
                         input logic rs, input logic [4:0] ad,
                         input logic [63:0] wd);
    mem_exp_t m;
    m.nm = nm; m.ce = ce; m.we = we; m.rs = rs; m.ad = ad; m.wd = wd;
    mem_q.push_back(m);
  endtask

  task automatic exp_st(input string nm, input logic [2:0] st,
                        input logic y, input logic en,
                        input logic [4:0] sa, input logic cr,
                        input logic [63:0] rd);
    st_exp_t s;
    s.nm = nm; s.st = st; s.y = y; s.en = en; s.sa = sa;
    s.cr = cr; s.rd = rd;
    st_q.push_back(s);
  endtask

  always @(negedge clk) begin : monitor
    mem_exp_t me;
    st_exp_t  se;
    logic [3:0] cur;
    if (mon_on) begin
      if (mif.sw_cs && mif.grant) begin
        if (mem_q.size() == 0) begin
          unexpected("mem_unexp", {mif.sw_ce, mif.sw_we, reset,
                                   mif.sw_add, mif.sw_wdat});
        end else begin
          me = mem_q.pop_front();
          chk(me.nm, {mif.sw_ce, mif.sw_we, reset, mif.sw_add, mif.sw_wdat},
              {me.ce, me.we, me.rs, me.ad, me.wd});
        end
      end
      cur = {stat_code, mif.yield};
      if (cur !== prev) begin
        if (st_q.size() == 0) begin
          unexpected("stat_unexp", {cur, enable, stat_addr});
        end else begin
          se = st_q.pop_front();
          chk(se.nm, {stat_code, mif.yield, enable, stat_addr},
              {se.st, se.y, se.en, se.sa});
          if (se.cr) chk({se.nm, "_rd"}, rd_dat, se.rd);
        end
      end
      prev = cur;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cmd(input logic [3:0] op, input logic [4:0] ad);
    wr_stb    = 1'b1;
    reg_addr  = 11'h40C;
    cmnd_op   = op;
    cmnd_addr = ad;
    @(posedge clk);
    #1;
    wr_stb   = 1'b0;
    reg_addr = 11'h000;
    cmnd_op  = 4'd0;
  endtask

  initial begin
    rst_n         = 1'b0;
    wr_stb        = 1'b0;
    reg_addr      = 11'h000;
    cmnd_op       = 4'd0;
    cmnd_addr     = 5'd0;
    cmnd_table_id = 1'b0;
    addr_limit    = 5'd31;
    wr_dat        = 64'h0;
    mif.sw_rdat   = 64'h0;
    mif.sw_match  = 1'b0;
    mif.sw_aindex = 4'h0;
    mif.grant     = 1'b1;
    tick(3);
    rst_n = 1'b1;

    chk("rst_stat", stat_code, 3'd0);
    chk("rst_rd", rd_dat, 64'h0);
    chk("rst_strobes", {mif.sw_cs, mif.sw_ce, mif.sw_we, reset, mif.yield},
        5'b0);
    chk("rst_enable", enable, 1'b1);
    chk("rst_stat_addr", stat_addr, 5'd31);
    chk("const_caps", {capability_lst, capability_type}, 20'h80232);
    chk("const_dw_tid", {stat_datawords, stat_table_id}, 6'b000010);

    prev   = {stat_code, mif.yield};
    mon_on = 1'b1;

    // wrong register address must not decode
    wr_stb = 1'b1; reg_addr = 11'h40D; cmnd_op = 4'd2; cmnd_addr = 5'd1;
    tick(1);
    wr_stb = 1'b0; reg_addr = 11'h000; cmnd_op = 4'd0;
    tick(2);
    chk("decoy_stat", stat_code, 3'd0);

    wr_dat = 64'hA5;
    exp_mem("wr_cyc", 1'b0, 1'b1, 1'b0, 5'd3, 64'hA5);
    exp_st("wr_busy", 3'd1, 1'b0, 1'b1, 5'd31, 1'b0, 64'h0);
    exp_st("wr_done", 3'd0, 1'b0, 1'b1, 5'd31, 1'b0, 64'h0);
    cmd(4'd2, 5'd3);
    tick(3);

    mif.sw_rdat = 64'h1234;
    exp_mem("rd_cyc", 1'b0, 1'b0, 1'b0, 5'd7, 64'hA5);
    exp_st("rd_busy", 3'd1, 1'b0, 1'b1, 5'd31, 1'b0, 64'h0);
    exp_st("rd_done", 3'd0, 1'b0, 1'b1, 5'd31, 1'b1, 64'h1234);
    cmd(4'd1, 5'd7);
    tick(4);

    mif.sw_match  = 1'b1;
    mif.sw_aindex = 4'h5;
    exp_mem("cmp_cyc", 1'b1, 1'b0, 1'b0, 5'd4, 64'hA5);
    exp_st("cmp_busy", 3'd1, 1'b0, 1'b1, 5'd31, 1'b0, 64'h0);
    exp_st("cmp_done", 3'd0, 1'b0, 1'b1, 5'd31, 1'b1, 64'h15);
    cmd(4'd9, 5'd4);
    tick(5);

    addr_limit = 5'd5;
    exp_st("nxm", 3'd4, 1'b0, 1'b1, 5'd5, 1'b0, 64'h0);
    cmd(4'd1, 5'd6);
    tick(2);
    exp_st("nxm_ack", 3'd0, 1'b0, 1'b1, 5'd5, 1'b0, 64'h0);
    cmd(4'd15, 5'd0);
    tick(2);
    addr_limit = 5'd31;

    exp_st("uop", 3'd5, 1'b0, 1'b1, 5'd31, 1'b0, 64'h0);
    cmd(4'd11, 5'd0);
    tick(2);
    exp_st("uop_ack", 3'd0, 1'b0, 1'b1, 5'd31, 1'b0, 64'h0);
    cmd(4'd15, 5'd0);
    tick(2);

    // grant is held high but masked by the simulated timeout
    wr_dat = 64'h77;
    cmd(4'd14, 5'd0);
    tick(1);
    for (int i = 0; i < 15; i++)
      exp_mem("tmo_cyc", 1'b0, 1'b1, 1'b0, 5'd9, 64'h77);
    exp_st("tmo_busy", 3'd1, 1'b0, 1'b1, 5'd31, 1'b0, 64'h0);
    exp_st("tmo_yield", 3'd1, 1'b1, 1'b1, 5'd31, 1'b0, 64'h0);
    exp_st("tmo", 3'd2, 1'b0, 1'b1, 5'd31, 1'b0, 64'h0);
    cmd(4'd2, 5'd9);
    tick(20);
    exp_st("tmo_ack", 3'd0, 1'b0, 1'b1, 5'd31, 1'b0, 64'h0);
    cmd(4'd15, 5'd0);
    tick(2);

    mif.grant = 1'b0;
    exp_st("ovr_busy", 3'd1, 1'b0, 1'b1, 5'd31, 1'b0, 64'h0);
    exp_st("ovr", 3'd3, 1'b0, 1'b1, 5'd31, 1'b0, 64'h0);
    cmd(4'd2, 5'd1);
    cmd(4'd1, 5'd1);
    tick(2);
    exp_st("ovr_ack", 3'd0, 1'b0, 1'b1, 5'd31, 1'b0, 64'h0);
    cmd(4'd15, 5'd0);
    tick(2);

    exp_st("abort_busy", 3'd1, 1'b0, 1'b1, 5'd31, 1'b0, 64'h0);
    cmd(4'd1, 5'd2);
    tick(2);
    exp_st("abort", 3'd0, 1'b0, 1'b1, 5'd31, 1'b1, 64'h0);
    rst_n = 1'b0;
    tick(1);
    rst_n = 1'b1;
    chk("abort_cs", mif.sw_cs, 1'b0);
    mif.grant = 1'b1;
    tick(2);

    wr_dat = 64'hBEEF;
    cmd(4'd8, 5'd2);
    exp_mem("rst_cyc", 1'b0, 1'b1, 1'b1, 5'd0, 64'h0);
    exp_st("rst_busy", 3'd1, 1'b0, 1'b1, 5'd31, 1'b0, 64'h0);
    exp_st("rst_done", 3'd0, 1'b0, 1'b1, 5'd31, 1'b0, 64'h0);
    cmd(4'd5, 5'd0);
    tick(2);
    for (int i = 0; i < 4; i++)
      exp_mem("init_cyc", 1'b0, 1'b1, 1'b0, 5'(i), 64'hBEEF);
    exp_st("init_busy", 3'd1, 1'b0, 1'b1, 5'd31, 1'b0, 64'h0);
    exp_st("init_done", 3'd0, 1'b0, 1'b1, 5'd31, 1'b0, 64'h0);
    cmd(4'd6, 5'd3);
    tick(6);

    cmd(4'd8, 5'd2);
    exp_mem("inc_cyc", 1'b0, 1'b1, 1'b0, 5'd2, 64'hBEEF);
    exp_mem("inc_cyc", 1'b0, 1'b1, 1'b0, 5'd3, 64'hBEEF);
    exp_st("inc_busy", 3'd1, 1'b0, 1'b1, 5'd31, 1'b0, 64'h0);
    exp_st("inc_done", 3'd0, 1'b0, 1'b1, 5'd31, 1'b0, 64'h0);
    cmd(4'd7, 5'd3);
    tick(4);

    wr_dat = 64'h5A5A;
    exp_st("pdn", 3'd7, 1'b0, 1'b0, 5'd0, 1'b0, 64'h0);
    cmd(4'd4, 5'd0);
    tick(3);
    exp_st("en", 3'd0, 1'b0, 1'b1, 5'd31, 1'b1, 64'h5A5A);
    cmd(4'd3, 5'd0);
    tick(3);

    chk("mem_q_left", mem_q.size(), 0);
    chk("st_q_left", st_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
